braun_mac: RTL and testbench
============================

# braun_mac

Streaming multiply-accumulate stage built around the combinational `braun_mult` array. It accepts operand pairs over a valid/ready handshake and registers each Braun product. It sums `DOT_LEN` consecutive products into one dot-product result, which it presents on a valid/ready output port. It is the sequential stage directly downstream of `braun_mult`: it drives `braun_mult` operands and consumes its `prod`.

## Interface
- `NUM_BITS`, default 8: operand width; passed to `braun_mult`, whose product is `2*NUM_BITS` bits.
- `DOT_LEN`, default 4: number of products per result; must be ≥ 1.
- `ACC_BITS`, default 18: accumulator and result width; must be ≥ `2*NUM_BITS`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `in_a`  in  `NUM_BITS`  unsigned multiplicand.
- `in_b`  in  `NUM_BITS`  unsigned multiplier.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_acc`  out  `ACC_BITS`  dot-product result, modulo 2^`ACC_BITS`.
- `out_ovf`  out  1  set if any addition in this result carried out of `ACC_BITS`.

## Operation
- An operand pair is accepted in any cycle where `in_valid & in_ready` is true.
- `braun_mult` is instantiated with `a=in_a` and `b=in_b`. On accept: `prod_q <= prod`, `p_valid <= 1`. Otherwise `p_valid <= 0`.
- The element counter `cnt` (0..`DOT_LEN-1`) increments on each accept and wraps to 0 on the `DOT_LEN`-th accept.
- FSM states:
  - `S_ACC`: `in_ready=1`. If `p_valid`, `acc <= acc + zext(prod_q)`. Accepting with `cnt==DOT_LEN-1` moves to `S_FLUSH`.
  - `S_FLUSH`: `in_ready=0`.
    - `out_acc <= acc + zext(prod_q)` (`p_valid` is always 1 here).
    - `out_ovf <= ovf_sticky | carry`.
    - `acc <= 0`, `ovf_sticky <= 0`, `out_valid <= 1`.
    - Moves to `S_OUT`.
  - `S_OUT`: `in_ready=0`. `out_valid` and `out_acc` are held stable. On `out_ready`, `out_valid <= 0` and the FSM moves to `S_ACC`.
- Arithmetic is unsigned. The sum is computed at `ACC_BITS+1` bits:
  - The low `ACC_BITS` bits are stored (wrap-around).
  - Bit `ACC_BITS` sets `ovf_sticky`.
- Stalls: while `in_valid=0` mid-vector, `acc` and `cnt` hold; there are no partial outputs.
- `DOT_LEN=1`: every accept goes directly to `S_FLUSH`.
- Reset, asynchronous and possibly mid-vector or mid-output:
  - State returns to `S_ACC`; `cnt`, `acc`, `ovf_sticky`, `prod_q` and `p_valid` are cleared.
  - `out_valid=0`, `out_acc=0`, `out_ovf=0`.
  - Partial results are discarded.
  - `in_ready` is 1 while in `S_ACC`, including during reset.

## Timing
- `in_ready` is a combinational decode of state only (`state==S_ACC`). It does not depend on `in_valid` or `out_ready`.
- Product latency: the pair accepted in cycle m is added into `acc` at the end of cycle m+1.
- Result latency: if the last element of a vector is accepted in cycle n, `out_valid` is high from cycle n+2.
- The result is held until the `out_valid & out_ready` cycle. `in_ready` returns high the cycle after that handshake.
- Peak throughput is one result per `DOT_LEN+2` cycles with `out_ready` tied high.
- `out_acc` and `out_ovf` change only on the `S_FLUSH` edge or on reset.
- A simultaneous `in_valid` in `S_FLUSH`/`S_OUT` is ignored and is not accepted.

## Test plan
- Reset check: hold `rst_n=0`. Required: `out_valid=0`, `out_acc=0`, `out_ovf=0`, `in_ready=1`.
- Basic dot product, `DOT_LEN=4`, back-to-back pairs (1,2),(3,4),(5,6),(7,8) starting cycle 1, `out_ready=1`. Required:
  - `out_valid` high in cycle 6, with `out_acc=100` and `out_ovf=0`.
  - `in_ready` is 0 in cycles 5–6 and 1 in cycle 7.
- Maximum operands: 4×(255,255) with default `ACC_BITS=18`. Required: `out_acc=260100`, `out_ovf=0`.
  - Same stimulus with `ACC_BITS=16`. Required: `out_acc=63492`, `out_ovf=1`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` rises. Required:
  - `out_acc` is stable and `in_ready=0` throughout.
  - `in_valid` pulses during the hold are not counted.
  - The next vector (0,9)×4 yields 0.
- Bubbles: insert 3 idle cycles between elements 2 and 3 of (2,3)×4. Required: a single result of 24; `acc` holds during the idle cycles.
- Mid-vector reset: assert `rst_n=0` after 2 accepts of (10,10), then send (1,1)×4. Required: result 4, not 204.
- Randomized: random pairs compared against a reference model of Σa·b mod 2^`ACC_BITS` plus the overflow flag, for 100 vectors with random `out_ready`.

Source files
------------

// File: rtl/braun_mac.sv
// braun_mac: streaming multiply-accumulate stage around a Braun array
// multiplier. Operand pairs are accepted over a valid/ready handshake,
// each product is registered, DOT_LEN products are summed into one
// dot-product result that is offered on a valid/ready output port.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand pair valid
//   in_ready  out  block can accept an operand pair (state==S_ACC)
//   in_a      in   NUM_BITS unsigned multiplicand
//   in_b      in   NUM_BITS unsigned multiplier
//   out_valid out  result valid
//   out_ready in   consumer accepts result
//   out_acc   out  ACC_BITS dot-product result, modulo 2^ACC_BITS
//   out_ovf   out  any addition of this result carried out of ACC_BITS

module braun_mult #(
   parameter int NUM_BITS = 8
) (
   input  logic [NUM_BITS-1:0]   a,
   input  logic [NUM_BITS-1:0]   b,
   output logic [2*NUM_BITS-1:0] prod
);

   logic [NUM_BITS-1:0] s;
   logic [NUM_BITS-1:0] c;
   logic [NUM_BITS-1:0] sh;
   logic [NUM_BITS-1:0] ns;
   logic [NUM_BITS-1:0] nc;
   logic                x;
   logic                cy;

   // Carry-save rows: after row i, s[j] has weight 2^(i+j) and c[j]
   // weight 2^(i+j+1). The last row is resolved by a ripple adder.
   always_comb begin
      s    = '0;
      c    = '0;
      sh   = '0;
      ns   = '0;
      nc   = '0;
      x    = 1'b0;
      cy   = 1'b0;
      prod = '0;
      for (int j = 0; j < NUM_BITS; j++)
         s[j] = a[j] & b[0];
      prod[0] = s[0];
      for (int i = 1; i < NUM_BITS; i++) begin
         sh = s >> 1;
         for (int j = 0; j < NUM_BITS; j++) begin
            x     = a[j] & b[i];
            ns[j] = x ^ sh[j] ^ c[j];
            nc[j] = (x & sh[j]) | (x & c[j]) | (sh[j] & c[j]);
         end
         s       = ns;
         c       = nc;
         prod[i] = s[0];
      end
      sh = s >> 1;
      cy = 1'b0;
      for (int j = 0; j < NUM_BITS; j++) begin
         prod[NUM_BITS+j] = sh[j] ^ c[j] ^ cy;
         cy = (sh[j] & c[j]) | (sh[j] & cy) | (c[j] & cy);
      end
   end

endmodule

module braun_mac #(
   parameter int NUM_BITS = 8,
   parameter int DOT_LEN  = 4,
   parameter int ACC_BITS = 18
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] in_a,
   input  logic [NUM_BITS-1:0] in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_BITS-1:0] out_acc,
   output logic                out_ovf
);

   localparam int PW = 2 * NUM_BITS;
   localparam int CW = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(DOT_LEN - 1);

   typedef enum logic [1:0] {
      S_ACC,
      S_FLUSH,
      S_OUT
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [PW-1:0]       prod;
   logic [PW-1:0]       prod_q;
   logic                p_valid;
   logic [CW-1:0]       cnt;
   logic [ACC_BITS-1:0] acc;
   logic                ovf_sticky;
   logic [ACC_BITS:0]   sum;
   logic                accept;
   logic                last;

   braun_mult #(
      .NUM_BITS(NUM_BITS)
   ) u_mult (
      .a    (in_a),
      .b    (in_b),
      .prod (prod)
   );

   // One extra bit catches the carry out of the accumulator width.
   assign sum    = {1'b0, acc}
                 + {{(ACC_BITS + 1 - PW){1'b0}}, prod_q};
   assign accept = in_valid & in_ready;
   assign last   = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_ACC;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      unique case (state_q)
         S_ACC: begin
            in_ready = 1'b1;
            if (in_valid && last)
               state_d = S_FLUSH;
         end
         S_FLUSH: state_d = S_OUT;
         S_OUT: begin
            if (out_ready)
               state_d = S_ACC;
         end
         default: state_d = S_ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q     <= '0;
         p_valid    <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         ovf_sticky <= 1'b0;
         out_valid  <= 1'b0;
         out_acc    <= '0;
         out_ovf    <= 1'b0;
      end else begin
         p_valid <= accept;
         if (accept) begin
            prod_q <= prod;
            cnt    <= last ? '0 : cnt + CW'(1);
         end
         if (state_q == S_ACC && p_valid) begin
            acc        <= sum[ACC_BITS-1:0];
            ovf_sticky <= ovf_sticky | sum[ACC_BITS];
         end
         // The final product is still in prod_q while flushing.
         if (state_q == S_FLUSH) begin
            out_acc    <= sum[ACC_BITS-1:0];
            out_ovf    <= ovf_sticky | sum[ACC_BITS];
            acc        <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b1;
         end
         if (state_q == S_OUT && out_ready)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_braun_mac.sv
// Testbench for braun_mac: table vectors, reset sequences and random
// vectors checked against a plain-arithmetic dot-product model.
module tb_braun_mac;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        out_ready;
   logic        rdy18, rdy16;
   logic        ov18, ov16;
   logic [17:0] acc18;
   logic [15:0] acc16;
   logic        of18, of16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   braun_mac #(.NUM_BITS(8), .DOT_LEN(4), .ACC_BITS(18)) d18 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy18),
      .in_a(in_a), .in_b(in_b), .out_valid(ov18), .out_ready(out_ready),
      .out_acc(acc18), .out_ovf(of18)
   );

   braun_mac #(.NUM_BITS(8), .DOT_LEN(4), .ACC_BITS(16)) d16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
      .in_a(in_a), .in_b(in_b), .out_valid(ov16), .out_ready(out_ready),
      .out_acc(acc16), .out_ovf(of16)
   );

   typedef struct {
      logic [3:0][7:0] a;
      logic [3:0][7:0] b;
      int              gap_at;
      int              gap_len;
      int              hold;
      logic [17:0]     e18;
      logic            e18o;
      logic [15:0]     e16;
      logic            e16o;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs;
      chk("rst_ov18", ov18, 0);
      chk("rst_acc18", acc18, 0);
      chk("rst_of18", of18, 0);
      chk("rst_rdy18", rdy18, 1);
      chk("rst_ov16", ov16, 0);
      chk("rst_acc16", acc16, 0);
      chk("rst_of16", of16, 0);
      chk("rst_rdy16", rdy16, 1);
   endtask

   task automatic chk_result(input logic [17:0] e18, input logic e18o,
                             input logic [15:0] e16, input logic e16o);
      chk("ov18", ov18, 1);
      chk("ov16", ov16, 1);
      chk("out_rdy", rdy18, 0);
      chk("acc18", acc18, e18);
      chk("ovf18", of18, e18o);
      chk("acc16", acc16, e16);
      chk("ovf16", of16, e16o);
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b);
      int w;
      w = 0;
      while (!rdy18 && w < 50) begin
         in_valid = 1'b0;
         tick();
         w++;
      end
      if (w >= 50) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_vec(input logic [3:0][7:0] a,
                          input logic [3:0][7:0] b,
                          input int gap_at, input int gap_len,
                          input int hold, input bit rnd_rdy,
                          input logic [17:0] e18, input logic e18o,
                          input logic [15:0] e16, input logic e16o);
      int w;
      out_ready = (hold == 0 && !rnd_rdy);
      for (int i = 0; i < 4; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               in_valid = 1'b0;
               tick();
               chk("no_partial", ov18, 0);
            end
         end
         send(a[i], b[i]);
      end
      chk("flush_rdy", rdy18, 0);
      chk("flush_ov", ov18, 0);
      tick();
      chk_result(e18, e18o, e16, e16o);
      for (int k = 0; k < hold; k++) begin
         in_valid = k[0];
         in_a = 8'($urandom);
         in_b = 8'($urandom);
         tick();
         chk_result(e18, e18o, e16, e16o);
      end
      in_valid = 1'b0;
      if (rnd_rdy) begin
         w = 0;
         out_ready = 1'b0;
         while (!out_ready && w < 100) begin
            out_ready = 1'($urandom);
            tick();
            if (!out_ready) chk_result(e18, e18o, e16, e16o);
            w++;
         end
         if (!out_ready) chk("out_timeout", 0, 1);
      end else begin
         out_ready = 1'b1;
         tick();
      end
      chk("post_ov", ov18, 0);
      chk("post_rdy", rdy18, 1);
      out_ready = 1'b0;
   endtask

   function automatic void model(input logic [3:0][7:0] a,
                                 input logic [3:0][7:0] b,
                                 output logic [17:0] e18,
                                 output logic e18o,
                                 output logic [15:0] e16,
                                 output logic e16o);
      longint tot;
      tot = 0;
      for (int i = 0; i < 4; i++)
         tot += longint'(a[i]) * longint'(b[i]);
      e18  = 18'(tot % (longint'(1) << 18));
      e18o = tot >= (longint'(1) << 18);
      e16  = 16'(tot % (longint'(1) << 16));
      e16o = tot >= (longint'(1) << 16);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got 0 want 1");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][7:0] ra, rb;
      logic [17:0] e18;
      logic [15:0] e16;
      logic e18o, e16o;

      tbl[0] = '{a: {8'd7, 8'd5, 8'd3, 8'd1},
                 b: {8'd8, 8'd6, 8'd4, 8'd2},
                 gap_at: 0, gap_len: 0, hold: 0,
                 e18: 18'd100, e18o: 0, e16: 16'd100, e16o: 0};
      tbl[1] = '{a: {4{8'd255}}, b: {4{8'd255}},
                 gap_at: 0, gap_len: 0, hold: 5,
                 e18: 18'd260100, e18o: 0, e16: 16'd63492, e16o: 1};
      tbl[2] = '{a: {4{8'd0}}, b: {4{8'd9}},
                 gap_at: 0, gap_len: 0, hold: 0,
                 e18: 18'd0, e18o: 0, e16: 16'd0, e16o: 0};
      tbl[3] = '{a: {4{8'd2}}, b: {4{8'd3}},
                 gap_at: 2, gap_len: 3, hold: 0,
                 e18: 18'd24, e18o: 0, e16: 16'd24, e16o: 0};
      tbl[4] = '{a: {8'd128, 8'd0, 8'd17, 8'd200},
                 b: {8'd128, 8'd255, 8'd33, 8'd100},
                 gap_at: 1, gap_len: 1, hold: 2,
                 e18: 18'd36945, e18o: 0, e16: 16'd36945, e16o: 0};
      tbl[5] = '{a: {8'd0, 8'd1, 8'd255, 8'd255},
                 b: {8'd0, 8'd1, 8'd255, 8'd255},
                 gap_at: 3, gap_len: 2, hold: 0,
                 e18: 18'd130051, e18o: 0, e16: 16'd64515, e16o: 1};

      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b0;
      #12;
      chk_reset_outs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++)
         run_vec(tbl[t].a, tbl[t].b, tbl[t].gap_at, tbl[t].gap_len,
                 tbl[t].hold, 1'b0, tbl[t].e18, tbl[t].e18o,
                 tbl[t].e16, tbl[t].e16o);

      // Mid-vector reset discards the partial sum.
      send(8'd10, 8'd10);
      send(8'd10, 8'd10);
      rst_n = 1'b0;
      #2;
      chk_reset_outs();
      tick();
      rst_n = 1'b1;
      run_vec({4{8'd1}}, {4{8'd1}}, 0, 0, 0, 1'b0,
              18'd4, 1'b0, 16'd4, 1'b0);

      // Reset while a result is being held.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'd3, 8'd3);
      tick();
      chk("pre_rst_ov", ov18, 1);
      rst_n = 1'b0;
      #2;
      chk_reset_outs();
      tick();
      rst_n = 1'b1;

      for (int v = 0; v < 100; v++) begin
         for (int i = 0; i < 4; i++) begin
            ra[i] = 8'($urandom);
            rb[i] = 8'($urandom);
         end
         model(ra, rb, e18, e18o, e16, e16o);
         run_vec(ra, rb, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 0, 1'b1,
                 e18, e18o, e16, e16o);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
